// File: rtl/aes_stream_ctrl.sv
// Framed 32-bit command front-end for aes_top: decodes a command word, assembles
// key/block, pulses the core, and streams the 128-bit result back as four words.
module aes_stream_ctrl #(
  parameter int KEY_S = 256,
  parameter int BLK_S = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             aes_en,
  output logic             aes128_mode,
  output logic             aes256_mode,
  output logic             cipher_mode,
  output logic             decipher_mode,
  output logic             key_exp_mode,
  output logic [KEY_S-1:0] aes_key,
  output logic [BLK_S-1:0] aes_in_blk,
  input  logic [BLK_S-1:0] aes_out_blk,
  input  logic             aes_en_o,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int KEY_W = KEY_S / 32;
  localparam int BLK_W = BLK_S / 32;

  // state | meaning
  // IDLE  | wait for command word      LOAD  | store key/block words
  // ISSUE | aes_en pulse               WAIT  | core busy, inputs frozen
  // SEND  | stream result out          DRAIN | discard rest of a bad frame
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t state, next_state;

  logic [2:0]       cnt;
  logic [1:0]       out_cnt;
  logic             op_kexp;
  logic             op_cipher;
  logic             op_decipher;
  logic             cmd_256;
  logic             key256;
  logic             key_loaded;
  logic [BLK_S-1:0] out_blk;

  logic       s_hs;
  logic       m_hs;
  logic       cmd_onehot;
  logic       cmd_bad;
  logic       last_word;
  logic [2:0] last_idx;
  logic       err_set;
  logic       done_set;
  logic       job;

  assign s_hs       = s_tvalid && s_tready;
  assign m_hs       = m_tvalid && m_tready;
  assign cmd_onehot = (s_tdata[2:0] == 3'b001) || (s_tdata[2:0] == 3'b010) ||
                      (s_tdata[2:0] == 3'b100);
  assign cmd_bad    = !cmd_onehot || (!s_tdata[0] && !key_loaded);
  assign last_idx   = (op_kexp && cmd_256) ? 3'(KEY_W - 1) : 3'(BLK_W - 1);
  assign last_word  = (cnt == last_idx);

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (s_hs) begin
          if (cmd_bad) begin
            if (s_tlast) err_set = 1'b1;
            else         next_state = DRAIN;
          end else begin
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        if (s_hs) begin
          if (last_word) begin
            next_state = s_tlast ? ISSUE : DRAIN;
          end else if (s_tlast) begin
            err_set    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (aes_en_o) begin
          if (op_kexp) begin
            done_set   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = SEND;
          end
        end
      end
      SEND: begin
        if (m_hs && (out_cnt == 2'd3)) next_state = IDLE;
      end
      DRAIN: begin
        if (s_hs && s_tlast) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Mode lines are only driven while a job is with the core; the key size for
  // cipher/decipher comes from the last completed key expansion.
  always_comb begin
    job           = (state == ISSUE) || (state == WAIT);
    s_tready      = (state == IDLE) || (state == LOAD) || (state == DRAIN);
    aes_en        = (state == ISSUE);
    busy          = (state != IDLE);
    m_tvalid      = (state == SEND);
    m_tlast       = (state == SEND) && (out_cnt == 2'd3);
    key_exp_mode  = job && op_kexp;
    cipher_mode   = job && op_cipher;
    decipher_mode = job && op_decipher;
    aes256_mode   = job && (op_kexp ? cmd_256 : key256);
    aes128_mode   = job && !(op_kexp ? cmd_256 : key256);
  end

  always_comb begin
    m_tdata = '0;
    if (state == SEND) begin
      case (out_cnt)
        2'd0:    m_tdata = out_blk[BLK_S-1  -: 32];
        2'd1:    m_tdata = out_blk[BLK_S-33 -: 32];
        2'd2:    m_tdata = out_blk[BLK_S-65 -: 32];
        default: m_tdata = out_blk[BLK_S-97 -: 32];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      out_cnt     <= '0;
      op_kexp     <= 1'b0;
      op_cipher   <= 1'b0;
      op_decipher <= 1'b0;
      cmd_256     <= 1'b0;
      key256      <= 1'b0;
      key_loaded  <= 1'b0;
      out_blk     <= '0;
      aes_key     <= '0;
      aes_in_blk  <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= next_state;
      done  <= done_set;
      err   <= err_set;
      case (state)
        IDLE: begin
          if (s_hs && !cmd_bad) begin
            op_kexp     <= s_tdata[0];
            op_cipher   <= s_tdata[1];
            op_decipher <= s_tdata[2];
            cmd_256     <= s_tdata[4];
            cnt         <= '0;
            if (s_tdata[0] && !s_tdata[4]) aes_key[KEY_S/2-1:0] <= '0;
          end
        end
        LOAD: begin
          if (s_hs) begin
            cnt <= cnt + 3'd1;
            if (op_kexp) begin
              for (int i = 0; i < KEY_W; i++) begin
                if (cnt == 3'(i)) aes_key[KEY_S-1-32*i -: 32] <= s_tdata;
              end
            end else begin
              for (int i = 0; i < BLK_W; i++) begin
                if (cnt == 3'(i)) aes_in_blk[BLK_S-1-32*i -: 32] <= s_tdata;
              end
            end
          end
        end
        WAIT: begin
          if (aes_en_o) begin
            if (op_kexp) begin
              key_loaded <= 1'b1;
              key256     <= cmd_256;
            end else begin
              out_blk <= aes_out_blk;
              out_cnt <= '0;
            end
          end
        end
        SEND: begin
          if (m_hs) out_cnt <= out_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: a behavioural core answers with known AES vectors,
// output words are checked against a queue filled when each frame is driven.
module tb_aes_stream_ctrl;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef logic [31:0] wq_t[$];

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic         aes_en;
  logic         aes128_mode;
  logic         aes256_mode;
  logic         cipher_mode;
  logic         decipher_mode;
  logic         key_exp_mode;
  logic [255:0] aes_key;
  logic [127:0] aes_in_blk;
  logic [127:0] aes_out_blk = '0;
  logic         aes_en_o = 1'b0;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.KEY_S(256), .BLK_S(128)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .aes_en(aes_en), .aes128_mode(aes128_mode), .aes256_mode(aes256_mode),
    .cipher_mode(cipher_mode), .decipher_mode(decipher_mode), .key_exp_mode(key_exp_mode),
    .aes_key(aes_key), .aes_in_blk(aes_in_blk), .aes_out_blk(aes_out_blk),
    .aes_en_o(aes_en_o), .busy(busy), .done(done), .err(err)
  );

  int          total = 0;
  int          bad = 0;
  int          en_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  bit          kill = 1'b0;
  logic [4:0]  exp_mode = '0;  // {aes256, aes128, decipher, cipher, key_exp}
  logic [32:0] exp_q[$];

  // Behavioural core: fixed latency, answers only the known vectors correctly.
  int           core_cnt = 0;
  logic [255:0] core_key = '0;
  logic         core_256 = 1'b0;
  logic [127:0] core_res = '0;
  logic [4:0]   cap_mode = '0;
  logic [255:0] cap_key = '0;
  logic [127:0] cap_blk = '0;

  function automatic logic [127:0] core_fn(input logic cip, input logic dec,
                                           input logic [255:0] k, input logic k256,
                                           input logic [127:0] b);
    logic key_ok;
    key_ok = k256 ? (k == K256) : (k[255:128] == K128);
    if (cip && key_ok && b == PT) return k256 ? CT256 : CT128;
    if (dec && key_ok && b == (k256 ? CT256 : CT128)) return PT;
    return ~b;
  endfunction

  always @(posedge clk) begin
    aes_en_o <= 1'b0;
    if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        aes_en_o    <= 1'b1;
        aes_out_blk <= core_res;
      end
    end
    if (aes_en) begin
      core_cnt <= 6;
      cap_mode <= {aes256_mode, aes128_mode, decipher_mode, cipher_mode, key_exp_mode};
      cap_key  <= aes_key;
      cap_blk  <= aes_in_blk;
      if (key_exp_mode) begin
        core_key <= aes_key;
        core_256 <= aes256_mode;
        core_res <= '0;
      end else begin
        core_res <= core_fn(cipher_mode, decipher_mode, core_key, core_256, aes_in_blk);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (m_tvalid && m_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_word unexpected got=%h last=%b", m_tdata, m_tlast);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            bad++;
            $display("FAIL out_word got=%b_%h exp=%b_%h", m_tlast, m_tdata, e[32], e[31:0]);
          end
        end
      end
      if (aes_en) begin
        en_cnt++;
        total++;
        if ({aes256_mode, aes128_mode, decipher_mode, cipher_mode, key_exp_mode} !== exp_mode) begin
          bad++;
          $display("FAIL issue_modes got=%b exp=%b", {aes256_mode, aes128_mode, decipher_mode,
                   cipher_mode, key_exp_mode}, exp_mode);
        end
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done || err) begin
        total++;
        if (done && err) begin
          bad++;
          $display("FAIL done_err_overlap got=11 exp=not both");
        end
      end
      if (aes_en_o && !kill) begin
        total++;
        if ({aes256_mode, aes128_mode, decipher_mode, cipher_mode, key_exp_mode} !== cap_mode ||
            aes_key !== cap_key || aes_in_blk !== cap_blk) begin
          bad++;
          $display("FAIL job_stable modes got=%b exp=%b key_ok=%b blk_ok=%b",
                   {aes256_mode, aes128_mode, decipher_mode, cipher_mode, key_exp_mode},
                   cap_mode, aes_key === cap_key, aes_in_blk === cap_blk);
        end
      end
    end
  end

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_word(input logic [31:0] d, input bit last);
    int n;
    n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    @(negedge clk);
    while (s_tready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (s_tready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_word_timeout got=s_tready %b exp=1", s_tready);
    end
    realign();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input wq_t w, input bit last_at_end);
    foreach (w[i]) send_word(w[i], last_at_end && (i == w.size() - 1));
  endtask

  task automatic push_blk(input logic [127:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), b[127-32*i -: 32]});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || m_tvalid) && n < budget);
    check("wait_idle_busy", {127'b0, busy}, 128'd0);
    realign();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    realign();
    realign();
    @(negedge clk);
    check("reset_outputs", {m_tdata, m_tvalid, m_tlast, aes_en, aes128_mode, aes256_mode,
          cipher_mode, decipher_mode, key_exp_mode, busy, done, err}, 128'd0);
    check("reset_key", aes_key[127:0] | aes_key[255:128], 128'd0);
    check("reset_blk", aes_in_blk, 128'd0);
    realign();
    reset = 1'b0;
    @(negedge clk);
    check("reset_tready", {126'b0, s_tready, busy}, 128'b10);
    realign();
  endtask

  task automatic test_no_key();
    int e0, r0;
    wq_t w;
    e0 = en_cnt;
    r0 = err_cnt;
    send_word(32'h2, 1'b0);
    @(negedge clk);
    check("nokey_drain", {125'b0, busy, s_tready, err}, 128'b110);
    realign();
    w = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    send_frame(w, 1'b1);
    @(negedge clk);
    check("nokey_err", {127'b0, err}, 128'd1);
    realign();
    realign();
    check("nokey_counts", {en_cnt - e0, err_cnt - r0}, {32'd0, 32'd1});
  endtask

  task automatic run_keyexp(input logic [31:0] cmd, input logic [255:0] key, input int nwords,
                            input logic [255:0] exp_key, input logic [4:0] mode);
    int e0, d0, n;
    wq_t w;
    e0 = en_cnt;
    d0 = done_cnt;
    exp_mode = mode;
    w = {};
    w.push_back(cmd);
    for (int i = 0; i < nwords; i++) w.push_back(key[255-32*i -: 32]);
    send_frame(w, 1'b1);
    @(negedge clk);
    check("kexp_en", {127'b0, aes_en}, 128'd1);
    check("kexp_key_hi", aes_key[255:128], exp_key[255:128]);
    check("kexp_key_lo", aes_key[127:0], exp_key[127:0]);
    n = 0;
    while (aes_en_o !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("kexp_core_done", {127'b0, aes_en_o}, 128'd1);
    @(negedge clk);
    check("kexp_done_pulse", {126'b0, done, busy}, 128'b10);
    realign();
    realign();
    check("kexp_counts", {en_cnt - e0, done_cnt - d0}, {32'd1, 32'd1});
    check("kexp_no_output", exp_q.size(), 128'd0);
  endtask

  task automatic run_job(input logic [31:0] cmd, input logic [127:0] blk,
                         input logic [127:0] exp_out, input logic [4:0] mode);
    int n;
    wq_t w;
    exp_mode = mode;
    push_blk(exp_out);
    w = '{cmd, blk[127:96], blk[95:64], blk[63:32], blk[31:0]};
    send_frame(w, 1'b1);
    @(negedge clk);
    check("job_en_latency", {127'b0, aes_en}, 128'd1);
    n = 0;
    while (aes_en_o !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("job_core_done", {127'b0, aes_en_o}, 128'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("job_tvalid_run", {126'b0, m_tvalid, s_tready}, 128'b10);
    end
    @(negedge clk);
    check("job_next_accept", {126'b0, s_tready, busy}, 128'b10);
    realign();
    check("job_queue_empty", exp_q.size(), 128'd0);
  endtask

  task automatic test_back_pressure();
    int n;
    wq_t w;
    logic [127:0] ct;
    ct = CT128;
    exp_mode = 5'b01010;
    m_tready = 1'b0;
    push_blk(ct);
    w = '{32'h2, PT[127:96], PT[95:64], PT[63:32], PT[31:0]};
    send_frame(w, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_tvalid !== 1'b1 && n < 50);
    check("bp_tvalid", {127'b0, m_tvalid}, 128'd1);
    realign();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        check("bp_hold", {94'b0, m_tvalid, s_tready, m_tlast, m_tdata},
              {94'b0, 1'b1, 1'b0, (i == 3), ct[127-32*i -: 32]});
      end
      realign();
      m_tready = 1'b1;
      realign();
      m_tready = 1'b0;
    end
    m_tready = 1'b1;
    @(negedge clk);
    check("bp_release", {126'b0, s_tready, m_tvalid}, 128'b10);
    realign();
    check("bp_queue_empty", exp_q.size(), 128'd0);
  endtask

  task automatic test_bad_cmd();
    int r0, e0;
    wq_t w;
    r0 = err_cnt;
    e0 = en_cnt;
    send_word(32'h3, 1'b0);
    @(negedge clk);
    check("badcmd_drain", {126'b0, busy, err}, 128'b10);
    realign();
    w = '{32'h1, 32'h2, 32'h3, 32'h4};
    send_frame(w, 1'b1);
    realign();
    realign();
    check("badcmd_counts", {en_cnt - e0, err_cnt - r0}, {32'd0, 32'd1});
  endtask

  task automatic test_short_frame();
    int r0, e0;
    wq_t w;
    r0 = err_cnt;
    e0 = en_cnt;
    w = '{32'h2, 32'h00112233, 32'h44556677};
    send_frame(w, 1'b1);
    @(negedge clk);
    check("short_err_idle", {126'b0, err, busy}, 128'b10);
    realign();
    realign();
    check("short_counts", {en_cnt - e0, err_cnt - r0}, {32'd0, 32'd1});
  endtask

  task automatic test_missing_tlast();
    int r0, e0;
    wq_t w;
    r0 = err_cnt;
    e0 = en_cnt;
    w = '{32'h2, PT[127:96], PT[95:64], PT[63:32], PT[31:0], 32'hdead0001};
    send_frame(w, 1'b0);
    @(negedge clk);
    check("missing_draining", {64'b0, 31'b0, busy, err_cnt - r0}, {64'b0, 31'b0, 1'b1, 32'd0});
    realign();
    send_word(32'hdead0002, 1'b1);
    @(negedge clk);
    check("missing_err", {127'b0, err}, 128'd1);
    realign();
    realign();
    check("missing_counts", {en_cnt - e0, err_cnt - r0}, {32'd0, 32'd1});
  endtask

  task automatic test_reset_wait();
    int r0, e0;
    wq_t w;
    exp_mode = 5'b01010;
    w = '{32'h2, PT[127:96], PT[95:64], PT[63:32], PT[31:0]};
    send_frame(w, 1'b1);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("rstw_in_wait", {126'b0, busy, s_tready}, 128'b10);
    realign();
    reset = 1'b1;
    kill  = 1'b1;
    realign();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rstw_quiet", {125'b0, m_tvalid, busy, s_tready}, 128'b001);
    end
    realign();
    kill = 1'b0;
    r0 = err_cnt;
    e0 = en_cnt;
    send_frame(w, 1'b1);
    @(negedge clk);
    check("rstw_cipher_err", {126'b0, err, busy}, 128'b10);
    realign();
    realign();
    check("rstw_counts", {en_cnt - e0, err_cnt - r0}, {32'd0, 32'd1});
    check("rstw_no_output", exp_q.size(), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    test_reset();
    test_no_key();
    run_keyexp(32'h11, K256, 8, K256, 5'b10001);
    run_job(32'h2, PT, CT256, 5'b10010);
    run_keyexp(32'h1, {K128, 128'h0}, 4, {K128, 128'h0}, 5'b01001);
    run_job(32'h2, PT, CT128, 5'b01010);
    run_job(32'h4, CT128, PT, 5'b01100);
    test_back_pressure();
    test_bad_cmd();
    test_short_frame();
    test_missing_tlast();
    test_reset_wait();
    wait_idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Upstream command front-end for `aes_top`. It accepts 32-bit framed command streams from the DMA side and decodes each frame's command word. It assembles the 256-bit key or 128-bit block, then drives `aes_top` with a one-cycle `en` pulse and stable mode lines. After `en_o`, it serializes the 128-bit result back out as four 32-bit words.

## Interface
- `KEY_S`, 256: key bus width, equal to the core's key width.
- `BLK_S`, 128: block bus width, equal to the core's block width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `s_tdata`  in  32  input stream data.
- `s_tvalid`  in  1  input word valid.
- `s_tlast`  in  1  marks the last word of a frame.
- `s_tready`  out  1  block accepts an input word this cycle.
- `m_tdata`  out  32  output stream data.
- `m_tvalid`  out  1  output word valid.
- `m_tlast`  out  1  set on the 4th output word.
- `m_tready`  in  1  sink accepts the output word.
- `aes_en`  out  1  one-cycle start pulse to the core (`en`).
- `aes128_mode`, `aes256_mode`  out  1 each  key-size select to the core; exactly one is high while a job is issued.
- `cipher_mode`, `decipher_mode`, `key_exp_mode`  out  1 each  operation select to the core; one-hot while a job is issued.
- `aes_key`  out  KEY_S  assembled key, left-aligned.
- `aes_in_blk`  out  BLK_S  assembled input block.
- `aes_out_blk`  in  BLK_S  core result.
- `aes_en_o`  in  1  core completion strobe.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when a key expansion completes.
- `err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Command word bit fields:
  - [0] key_exp, [1] cipher, [2] decipher. Exactly one must be set.
  - [4] aes256; 0 selects aes128. Used only for key_exp.
  - Other bits are ignored.
- Frame lengths, counting the command word:
  - key_exp/128: 5 words.
  - key_exp/256: 9 words.
  - cipher or decipher: 5 words.
- Data words arrive most-significant word first.
  - Key word i is written to `aes_key[KEY_S-1-32*i -: 32]`.
  - Block word i is written to `aes_in_blk[BLK_S-1-32*i -: 32]`.
  - Accepting a key_exp/128 command clears `aes_key[127:0]`.
- A key_exp completion sets `key_loaded` and latches `key256` from the command. Both are held until the next key_exp or reset.
- cipher and decipher drive `aes128_mode`/`aes256_mode` from the latched `key256`, not from command bit [4].
- FSM states:
  - IDLE: `s_tready`=1. On a word handshake, decode the command.
    - Invalid one-hot, or cipher/decipher with `key_loaded`=0, goes to DRAIN (or pulses `err` and stays in IDLE if `s_tlast`=1).
    - Otherwise go to LOAD with word counter = 0.
  - LOAD: `s_tready`=1. Each handshake stores a word and increments the counter.
    - `s_tlast`=1 before the last expected word: pulse `err`, go to IDLE, issue nothing.
    - Last expected word with `s_tlast`=1: go to ISSUE.
    - Last expected word with `s_tlast`=0: go to DRAIN.
  - ISSUE: `s_tready`=0. `aes_en`=1 for exactly this cycle. Go to WAIT.
  - WAIT: `s_tready`=0. On `aes_en_o`=1:
    - key_exp: pulse `done` next cycle, go to IDLE.
    - Otherwise capture `aes_out_blk` into the output register, go to SEND.
  - SEND: `m_tvalid`=1. `m_tdata` = captured bits [127:96], [95:64], [63:32], [31:0] in turn. Advance on `m_tvalid && m_tready`; `m_tlast`=1 on word 3. After the word-3 handshake go to IDLE.
  - DRAIN: `s_tready`=1. Discard words until a handshake with `s_tlast`=1, then pulse `err` and go to IDLE.
- Mode lines, `aes_key` and `aes_in_blk` must not change from ISSUE until the `aes_en_o` cycle.
- Mode lines are all 0 in IDLE.

## Timing
- Reset values:
  - FSM in IDLE; counters 0; `key_loaded`=0.
  - All outputs 0, including `aes_key`, `aes_in_blk` and `m_tdata`.
  - Exception: `s_tready`=1 from the first cycle after reset.
- Reset asserted mid-frame or mid-job aborts everything on that edge.
  - `aes_en_o` arriving after the reset is ignored because the FSM is in IDLE.
- Latency, with back-to-back valid words:
  - Last input word accepted at edge N; `aes_en`=1 in cycle N+1.
  - `aes_en_o` seen at edge M; `m_tvalid`=1 from cycle M+1.
  - With `m_tready` held at 1, the 4 output words take 4 cycles, and a new command is accepted the cycle after the last output word.
- `m_tvalid` and `m_tdata` hold while `m_tready`=0; `m_tdata` is stable under back-pressure.
- `s_tready`=0 throughout ISSUE, WAIT and SEND. No input is accepted while a job is outstanding.
- `done` and `err` are never asserted in the same cycle. Each pulses for exactly one cycle.

## Test plan
- Key expansion, 128-bit: frame {0x1, 00010203, 04050607, 08090a0b, 0c0d0e0f, tlast} with a real `aes_top`.
  - One `aes_en` pulse with `key_exp_mode`=1 and `aes128_mode`=1.
  - `aes_key` = 000102…0f followed by 128 zero bits.
  - `done` pulses once; no output words.
- Encrypt after that key: frame {0x2, 00112233, 44556677, 8899aabb, ccddeeff}.
  - Output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with `m_tlast` on the 4th.
  - Decrypt (0x4) of that ciphertext returns the plaintext.
- 256-bit key: key_exp 0x11 with 000102…1f (8 words).
  - Encrypt 00112233…eeff gives 8ea2b7ca 516745bf eafc4990 4b496089.
  - `aes256_mode`=1 during the job.
- Errors:
  - Cipher before any key: `err` pulses, words are drained until tlast, `aes_en` never asserts.
  - Command 0x3: `err` pulses.
  - tlast on the 3rd word of an encrypt frame: `err`, return to IDLE.
  - Missing tlast: frame is drained, `err` pulses at tlast.
- Back-pressure: hold `m_tready`=0 for 5 cycles on each output word.
  - Data holds stable, no words are lost, `s_tready`=0 until the last word is accepted.
- Reset during WAIT, then a late `aes_en_o`.
  - No output, `key_loaded`=0, and the next cipher command gets `err`.
